// File: rtl/ctrl_pipe_pkg.sv
// Shared defaults, stage indices and a keep-mask builder for ctrl_pipe.
// Latency: none (package only).
// Backpressure: none (package only).
package ctrl_pipe_pkg;

  localparam int DEF_WIDTH  = 19;
  localparam int DEF_STAGES = 3;
  localparam int DEF_CNT_W  = 32;

  // Stage indices for the default three-stage E/M/W arrangement.
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // Pack per-stage field masks into a KEEP_MASK value; E lands in the low slice.
  function automatic logic [DEF_STAGES*DEF_WIDTH-1:0] keep_mask3(
    input logic [DEF_WIDTH-1:0] e_mask,
    input logic [DEF_WIDTH-1:0] m_mask,
    input logic [DEF_WIDTH-1:0] w_mask
  );
    return {w_mask, m_mask, e_mask};
  endfunction

endpackage

// File: rtl/ctrl_pipe_reg.sv
// One pipeline stage: valid bit plus masked control bundle.
// Latency: one cycle from pred_* to valid/ctrl.
// Backpressure: hold keeps contents; kill and bubble clear to an empty stage.
module ctrl_pipe_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] KEEP  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             hold,
  input  logic             bubble,
  input  logic             pred_valid,
  input  logic [WIDTH-1:0] pred_ctrl,
  output logic             valid,
  output logic [WIDTH-1:0] ctrl
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] ctrl_q,  ctrl_d;

  // Next-state: kill beats hold beats bubble beats load; ctrl is zero whenever valid is.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (kill) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (hold) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end else if (bubble) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = pred_valid;
      ctrl_d  = pred_valid ? (pred_ctrl & KEEP) : '0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from decode through STAGES registers, with bubble counter.
// Latency: in_ctrl reaches stage k k+1 cycles after capture when nothing stalls.
// Backpressure: a stall holds its stage and all younger ones; in_ready = ~estall[0].
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                      WIDTH       = DEF_WIDTH,
  parameter int                      STAGES      = DEF_STAGES,
  parameter logic [STAGES*WIDTH-1:0] KEEP_MASK   = '1,
  parameter bit                      AUTO_BUBBLE = 1'b1,
  parameter int                      CNT_W       = DEF_CNT_W,
  localparam int                     EXC_W       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_ctrl,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    exc_flush,
  input  logic [EXC_W-1:0]        exc_stage,
  input  logic                    clr_cnt,
  output logic [STAGES*WIDTH-1:0] stage_ctrl,
  output logic [STAGES-1:0]       stage_valid,
  output logic [CNT_W-1:0]        bubble_cnt
);

  logic [STAGES-1:0] estall;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] bub;
  logic              bub_take;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Effective stall: any older stalled stage also holds every younger one.
  always_comb begin
    estall = '0;
    for (int i = 0; i < STAGES; i++) begin
      estall[i] = |(stall >> i);
    end
  end

  assign in_ready = ~estall[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pc;

    if (g == 0) begin : g_head
      assign pv     = in_valid;
      assign pc     = in_ctrl;
      assign bub[g] = 1'b0;
    end else begin : g_body
      assign pv     = stage_valid[g-1];
      assign pc     = stage_ctrl[(g-1)*WIDTH +: WIDTH];
      assign bub[g] = AUTO_BUBBLE & estall[g-1] & ~estall[g];
    end

    assign kill[g] = flush[g] | (exc_flush & (32'(g) <= 32'(exc_stage)));

    ctrl_pipe_reg #(
      .WIDTH (WIDTH),
      .KEEP  (KEEP_MASK[g*WIDTH +: WIDTH])
    ) u_reg (
      .clk        (clk),
      .rst        (rst),
      .kill       (kill[g]),
      .hold       (estall[g]),
      .bubble     (bub[g]),
      .pred_valid (pv),
      .pred_ctrl  (pc),
      .valid      (stage_valid[g]),
      .ctrl       (stage_ctrl[g*WIDTH +: WIDTH])
    );
  end

  // A bubble only counts when the receiving stage is not being killed anyway.
  assign bub_take = |(bub & ~kill);

  // Saturating bubble counter; clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (bub_take && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam int W = 19;
  localparam int S = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    in_ctrl;
  logic            in_valid;
  logic            in_ready, in_ready_m;
  logic [S-1:0]    stall, flush;
  logic            exc_flush;
  logic [1:0]      exc_stage;
  logic            clr_cnt;
  logic [S*W-1:0]  stage_ctrl, stage_ctrl_m;
  logic [S-1:0]    stage_valid, stage_valid_m;
  logic [31:0]     bubble_cnt;
  logic [1:0]      bubble_cnt_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .exc_flush(exc_flush), .exc_stage(exc_stage),
    .clr_cnt(clr_cnt), .stage_ctrl(stage_ctrl), .stage_valid(stage_valid),
    .bubble_cnt(bubble_cnt)
  );

  ctrl_pipe #(
    .KEEP_MASK (keep_mask3(19'h7FFFF, 19'h0007F, 19'h0001F)),
    .CNT_W     (2)
  ) dut_m (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready_m),
    .stall(stall), .flush(flush), .exc_flush(exc_flush), .exc_stage(exc_stage),
    .clr_cnt(clr_cnt), .stage_ctrl(stage_ctrl_m), .stage_valid(stage_valid_m),
    .bubble_cnt(bubble_cnt_m)
  );

  // Reference state: per-stage contents for both instances plus counters.
  logic         mv  [S];
  logic [W-1:0] mc  [S];
  logic [W-1:0] mc2 [S];
  logic [31:0]  mcnt;
  logic [1:0]   mcnt2;
  logic [W-1:0] mask2 [S];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Abstract model: find oldest stalled stage; everything at or below it holds,
  // the stage right after it receives a bubble, the rest shift forward.
  task automatic model_step();
    int           oldest;
    logic         nv  [S];
    logic [W-1:0] nc  [S];
    logic [W-1:0] nc2 [S];
    logic         bub;
    logic         killed;
    oldest = -1;
    bub    = 1'b0;
    for (int i = 0; i < S; i++) if (stall[i]) oldest = i;
    for (int i = 0; i < S; i++) begin
      killed = flush[i] || (exc_flush && (i <= int'(exc_stage)));
      if (rst || killed) begin
        nv[i] = 0; nc[i] = 0; nc2[i] = 0;
      end else if (i <= oldest) begin
        nv[i] = mv[i]; nc[i] = mc[i]; nc2[i] = mc2[i];
      end else if (i == oldest + 1 && i > 0) begin
        nv[i] = 0; nc[i] = 0; nc2[i] = 0; bub = 1'b1;
      end else if (i == 0) begin
        nv[i]  = in_valid;
        nc[i]  = in_valid ? in_ctrl : '0;
        nc2[i] = in_valid ? (in_ctrl & mask2[0]) : '0;
      end else begin
        nv[i]  = mv[i-1];
        nc[i]  = mc[i-1];
        nc2[i] = mc2[i-1] & mask2[i];
      end
    end
    for (int i = 0; i < S; i++) begin
      mv[i] = nv[i]; mc[i] = nc[i]; mc2[i] = nc2[i];
    end
    if (rst || clr_cnt) begin
      mcnt = 0; mcnt2 = 0;
    end else if (bub) begin
      if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
      if (mcnt2 != 2'd3) mcnt2 = mcnt2 + 1;
    end
  endtask

  task automatic compare_all();
    logic [S*W-1:0] ec, ec2;
    logic [S-1:0]   ev;
    for (int i = 0; i < S; i++) begin
      ec[i*W +: W]  = mc[i];
      ec2[i*W +: W] = mc2[i];
      ev[i]         = mv[i];
    end
    chk("stage_valid", 64'(stage_valid), 64'(ev));
    chk("stage_ctrl", 64'(stage_ctrl), 64'(ec));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(mcnt));
    chk("m_stage_valid", 64'(stage_valid_m), 64'(ev));
    chk("m_stage_ctrl", 64'(stage_ctrl_m), 64'(ec2));
    chk("m_bubble_cnt", 64'(bubble_cnt_m), 64'(mcnt2));
  endtask

  task automatic cycle(input logic r, input logic iv, input logic [W-1:0] ic,
                       input logic [S-1:0] st, input logic [S-1:0] fl,
                       input logic ef, input logic [1:0] es, input logic cc);
    rst = r; in_valid = iv; in_ctrl = ic; stall = st; flush = fl;
    exc_flush = ef; exc_stage = es; clr_cnt = cc;
    #1;
    chk("in_ready", 64'(in_ready), 64'(st == '0));
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input logic iv, input logic [W-1:0] ic, input logic [S-1:0] st);
    cycle(1'b0, iv, ic, st, '0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    mask2[0] = 19'h7FFFF; mask2[1] = 19'h0007F; mask2[2] = 19'h0001F;
    for (int i = 0; i < S; i++) begin mv[i] = 0; mc[i] = 0; mc2[i] = 0; end
    mcnt = 0; mcnt2 = 0;

    // Reset state
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 2'd0, 1'b0);
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_cnt", 64'(bubble_cnt), 64'd0);

    // Flow: one instruction walks E -> M -> W
    idle(1'b1, 19'h5A5A5, 3'b000);
    chk("flow_e", 64'(stage_ctrl[0 +: W]), 64'h5A5A5);
    idle(1'b0, 19'h12345, 3'b000);
    chk("flow_m", 64'(stage_ctrl[W +: W]), 64'h5A5A5);
    chk("flow_e_empty", 64'(stage_ctrl[0 +: W]), 64'h0);
    idle(1'b0, 19'h12345, 3'b000);
    chk("flow_w", 64'(stage_ctrl[2*W +: W]), 64'h5A5A5);
    chk("flow_w_vld", 64'(stage_valid), 64'b100);

    // Stall in M for two cycles with the pipe full
    idle(1'b1, 19'h0000A, 3'b000);
    idle(1'b1, 19'h0000B, 3'b000);
    idle(1'b1, 19'h0000C, 3'b000);
    idle(1'b1, 19'h0000D, 3'b010);
    idle(1'b1, 19'h0000D, 3'b010);
    chk("stall_vld", 64'(stage_valid), 64'b011);
    chk("stall_hold", 64'(stage_ctrl), 64'({19'h0, 19'h0000B, 19'h0000C}));
    chk("stall_cnt", 64'(bubble_cnt), 64'd2);

    // Exception on stages 0..1 while E is stalled: W takes old M
    cycle(1'b0, 1'b1, 19'h0000E, 3'b001, '0, 1'b1, 2'd1, 1'b0);
    chk("exc_vld", 64'(stage_valid), 64'b100);
    chk("exc_w", 64'(stage_ctrl[2*W +: W]), 64'h0000B);
    chk("exc_cnt", 64'(bubble_cnt), 64'd2);

    // Clear coincident with a bubble, then saturation of the narrow counter
    cycle(1'b0, 1'b1, 19'h00011, 3'b010, '0, 1'b0, 2'd0, 1'b1);
    chk("clr_cnt", 64'(bubble_cnt), 64'd0);
    for (int k = 0; k < 4; k++) idle(1'b1, 19'h00022, 3'b010);
    chk("sat_cnt_m", 64'(bubble_cnt_m), 64'd3);
    chk("cnt_full", 64'(bubble_cnt), 64'd4);

    // Per-stage field masking
    for (int k = 0; k < 3; k++) idle(1'b1, 19'h7FFFF, 3'b000);
    chk("mask_slices", 64'(stage_ctrl_m), 64'({19'h0001F, 19'h0007F, 19'h7FFFF}));

    // Reset mid-stream with stall[0]
    cycle(1'b1, 1'b1, 19'h7FFFF, 3'b001, '0, 1'b0, 2'd0, 1'b0);
    chk("rst_mid_vld", 64'(stage_valid), 64'd0);
    chk("rst_mid_ctrl", 64'(stage_ctrl), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      logic [S-1:0] st, fl;
      for (int b = 0; b < S; b++) begin
        st[b] = ($urandom_range(0, 5) == 0);
        fl[b] = ($urandom_range(0, 15) == 0);
      end
      cycle(($urandom_range(0, 199) == 0), 1'($urandom), 19'($urandom), st, fl,
            ($urandom_range(0, 15) == 0), 2'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
